// File: rtl/slot3_ctrl.sv
// Three-reel slot machine controller: reels advance on i_tick while spinning,
// i_btn stops them one at a time, and RESULT shows the win lamp for RESULT_TICKS ticks.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | waiting for i_btn, digits hold last game
// ST_SPIN3  | all three reels spinning
// ST_SPIN2  | reel 0 stopped, reels 1 and 2 spinning
// ST_SPIN1  | reels 0 and 1 stopped, reel 2 spinning
// ST_RESULT | all reels stopped, win lamp shown until RESULT_TICKS ticks
module slot3_ctrl #(
    parameter int unsigned RESULT_TICKS = 10
) (
    input  logic       clk,
    input  logic       i_sclr,
    input  logic       i_btn,
    input  logic       i_tick,
    output logic [3:0] o_digit0,
    output logic [3:0] o_digit1,
    output logic [3:0] o_digit2,
    output logic [2:0] o_spin,
    output logic       o_win,
    output logic       o_ledr,
    output logic       o_busy
);

    localparam logic [7:0] RESULT_TICKS_C = 8'(RESULT_TICKS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SPIN3,
        ST_SPIN2,
        ST_SPIN1,
        ST_RESULT
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] digit0_q, digit0_d;
    logic [3:0] digit1_q, digit1_d;
    logic [3:0] digit2_q, digit2_d;
    logic       win_q, win_d;
    logic       ledr_q, ledr_d;
    logic [7:0] cnt_q, cnt_d;
    logic       adv0, adv1, adv2;

    function automatic logic [3:0] add_mod10(input logic [3:0] d, input logic [3:0] n);
        logic [4:0] s;
        s = {1'b0, d} + {1'b0, n};
        if (s >= 5'd10) begin
            s = s - 5'd10;
        end
        return s[3:0];
    endfunction

    always_comb begin
        state_d  = state_q;
        digit0_d = digit0_q;
        digit1_d = digit1_q;
        digit2_d = digit2_q;
        win_d    = win_q;
        ledr_d   = ledr_q;
        cnt_d    = cnt_q;

        // The reel being stopped by i_btn does not advance on the same edge.
        adv0 = i_tick && (state_q == ST_SPIN3) && !i_btn;
        adv1 = i_tick && ((state_q == ST_SPIN3) || ((state_q == ST_SPIN2) && !i_btn));
        adv2 = i_tick && ((state_q == ST_SPIN3) || (state_q == ST_SPIN2) ||
                          ((state_q == ST_SPIN1) && !i_btn));

        if (adv0) digit0_d = add_mod10(digit0_q, 4'd1);
        if (adv1) digit1_d = add_mod10(digit1_q, 4'd9);
        if (adv2) digit2_d = add_mod10(digit2_q, 4'd3);

        case (state_q)
            ST_IDLE: begin
                if (i_btn) state_d = ST_SPIN3;
            end
            ST_SPIN3: begin
                if (i_btn) state_d = ST_SPIN2;
            end
            ST_SPIN2: begin
                if (i_btn) state_d = ST_SPIN1;
            end
            ST_SPIN1: begin
                if (i_btn) begin
                    state_d = ST_RESULT;
                    win_d   = (digit0_q == digit1_q) && (digit1_q == digit2_q);
                    ledr_d  = (digit0_q == digit1_q) && (digit1_q == digit2_q);
                    cnt_d   = 8'd0;
                end
            end
            ST_RESULT: begin
                if (i_btn) begin
                    state_d = ST_SPIN3;
                    win_d   = 1'b0;
                    ledr_d  = 1'b0;
                    cnt_d   = 8'd0;
                end else if (i_tick) begin
                    cnt_d  = cnt_q + 8'd1;
                    ledr_d = win_q ? ~ledr_q : 1'b0;
                    if (cnt_d == RESULT_TICKS_C) begin
                        state_d = ST_IDLE;
                        win_d   = 1'b0;
                        ledr_d  = 1'b0;
                        cnt_d   = 8'd0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_sclr) begin
            state_q  <= ST_IDLE;
            digit0_q <= 4'd0;
            digit1_q <= 4'd0;
            digit2_q <= 4'd0;
            win_q    <= 1'b0;
            ledr_q   <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            digit0_q <= digit0_d;
            digit1_q <= digit1_d;
            digit2_q <= digit2_d;
            win_q    <= win_d;
            ledr_q   <= ledr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_digit0 = digit0_q;
    assign o_digit1 = digit1_q;
    assign o_digit2 = digit2_q;
    assign o_win    = win_q;
    assign o_ledr   = ledr_q;
    assign o_busy   = (state_q != ST_IDLE);
    assign o_spin   = (state_q == ST_SPIN3) ? 3'b111 :
                      (state_q == ST_SPIN2) ? 3'b110 :
                      (state_q == ST_SPIN1) ? 3'b100 : 3'b000;

endmodule
